pipe_ctrl: RTL and testbench

Pipeline control unit that drives the per-stage `ok` (load enable) and `flush` (bubble insert) inputs of every inter-stage pipeline register in the core. It tracks a valid bit per stage, resolves back-pressure from stall requests, kills younger stages on branch redirect or exception, and serialises fence instructions by draining the back end. It sits beside the datapath and is the sole producer of `ok`/`flush` for the stage registers.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_hold_chain.sv | 31 +++
 rtl/pipe_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared stage indices, controller state encoding and counter type for the pipeline control unit.
package pipe_pkg;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_e;

    typedef logic [31:0] cnt_t;

    localparam cnt_t CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_hold_chain.sv
// Combinational hold chain and base load/bubble enables for every stage register.
// hold_force_i lets the caller pin stages as held without feeding back into the chain itself.
module pipe_hold_chain #(
    parameter int STAGES = 5
) (
    input  logic [STAGES-1:0] v_i,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic [STAGES-1:0] hold_force_i,
    output logic [STAGES-1:0] hold_o,
    output logic [STAGES-1:0] ok_o,
    output logic [STAGES-1:0] flush_o
);

    // Chain runs from the oldest stage down; an empty stage never holds.
    always_comb begin
        hold_o = '0;
        hold_o[STAGES-1] = v_i[STAGES-1] & stall_req_i[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold_o[i] = v_i[i] & (stall_req_i[i] | hold_o[i+1]);
        end
    end

    always_comb begin
        ok_o    = ~(hold_o | hold_force_i);
        flush_o = '0;
        for (int i = 1; i < STAGES; i++) begin
            flush_o[i] = ok_o[i] & (hold_o[i-1] | hold_force_i[i-1] | ~v_i[i-1]);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage load/bubble enables, valid tracking, redirect/exception kill,
// fence drain sequencing and a saturating fetch-stall counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES  = WB + 1,
    parameter int R_STAGE = EX,
    parameter int X_STAGE = MEM,
    parameter int F_STAGE = ID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid_i,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic              redirect_i,
    input  logic              exc_i,
    input  logic              fence_i,
    output logic [STAGES-1:0] ok_o,
    output logic [STAGES-1:0] flush_o,
    output logic [STAGES-1:0] valid_o,
    output logic [31:0]       stall_cnt_o
);

    localparam int X_LAST = (X_STAGE + 1 > STAGES - 1) ? STAGES - 1 : X_STAGE + 1;
    localparam logic [STAGES-1:0] R_BIT = {{(STAGES-1){1'b0}}, 1'b1} << R_STAGE;

    logic [STAGES-1:1] v_q, v_d;
    ctrl_state_e       state_q, state_d;
    cnt_t              cnt_q, cnt_d;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] hold, base_ok, base_flush, hold_force, kill;
    logic              redir_take, exc_take, older_busy, fence_hold;

    assign v           = {v_q, fetch_valid_i};
    assign valid_o     = v;
    assign stall_cnt_o = cnt_q;

    pipe_hold_chain #(.STAGES(STAGES)) u_hold_chain (
        .v_i          (v),
        .stall_req_i  (stall_req_i),
        .hold_force_i (hold_force),
        .hold_o       (hold),
        .ok_o         (base_ok),
        .flush_o      (base_flush)
    );

    // Kill set and fence hold depend only on the raw chain, never on the forced enables.
    always_comb begin
        redir_take = redirect_i & v[R_STAGE] & ~(|(hold & R_BIT));
        exc_take   = exc_i & v[X_STAGE];
        older_busy = |v_q[STAGES-1:F_STAGE+1];
        kill       = '0;
        for (int i = 1; i < STAGES; i++) begin
            kill[i] = (redir_take & (i <= R_STAGE)) | (exc_take & (i <= X_LAST));
        end
        if (state_q == RUN) begin
            fence_hold = ~kill[F_STAGE] & fence_i & v[F_STAGE] & older_busy;
        end else begin
            fence_hold = ~kill[F_STAGE] & older_busy;
        end
        hold_force = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold_force[i] = fence_hold & (i <= F_STAGE);
        end
    end

    always_comb begin
        ok_o    = base_ok | kill | {{(STAGES-1){1'b0}}, redir_take};
        flush_o = base_flush | kill;
        if (rst) begin
            ok_o    = '1;
            flush_o = {{(STAGES-1){1'b1}}, 1'b0};
        end

        v_d = v_q;
        for (int i = 1; i < STAGES; i++) begin
            if (ok_o[i]) begin
                v_d[i] = ~flush_o[i];
            end
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (fence_hold) state_d = DRAIN;
            DRAIN:   if (kill[F_STAGE] || !older_busy) state_d = RUN;
            default: state_d = RUN;
        endcase

        cnt_d = cnt_q;
        if (!ok_o[0] && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, stall, redirect, exception, fence drain and reset cases.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i;
    logic [4:0]  stall_req_i;
    logic        redirect_i;
    logic        exc_i;
    logic        fence_i;
    logic [4:0]  ok_o;
    logic [4:0]  flush_o;
    logic [4:0]  valid_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .STAGES  (5),
        .R_STAGE (2),
        .X_STAGE (3),
        .F_STAGE (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .stall_req_i   (stall_req_i),
        .redirect_i    (redirect_i),
        .exc_i         (exc_i),
        .fence_i       (fence_i),
        .ok_o          (ok_o),
        .flush_o       (flush_o),
        .valid_o       (valid_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, expv);
            $error("check %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            $error("check %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fetch_valid_i = 1'b0; stall_req_i = 5'b0;
        redirect_i = 1'b0; exc_i = 1'b0; fence_i = 1'b0;
        #1;
        chk5("rst_ok", ok_o, 5'b11111);
        chk5("rst_flush", flush_o, 5'b11110);
        tick(); tick();
        rst = 1'b0; #1;
        chk5("idle_valid", valid_o, 5'b00000);
        chk32("rst_cnt", stall_cnt_o, 32'd0);
        chk5("idle_ok", ok_o, 5'b11111);
        chk5("idle_flush", flush_o, 5'b11110);

        // fill
        fetch_valid_i = 1'b1; #1;
        chk5("fill0_valid", valid_o, 5'b00001);
        chk5("fill0_flush", flush_o, 5'b11100);
        tick(); tick();
        chk5("fill2_valid", valid_o, 5'b00111);
        chk5("fill2_flush", flush_o, 5'b10000);
        tick(); tick();
        chk5("full_valid", valid_o, 5'b11111);
        chk5("full_ok", ok_o, 5'b11111);
        chk5("full_flush", flush_o, 5'b00000);

        // stage 3 stalls for two cycles
        stall_req_i = 5'b01000; #1;
        chk5("stall_ok", ok_o, 5'b10000);
        chk5("stall_flush", flush_o, 5'b10000);
        tick();
        chk5("stall1_valid", valid_o, 5'b01111);
        chk5("stall1_ok", ok_o, 5'b10000);
        chk5("stall1_flush", flush_o, 5'b10000);
        tick();
        stall_req_i = 5'b0; #1;
        chk32("stall_cnt2", stall_cnt_o, 32'd2);
        chk5("unstall_valid", valid_o, 5'b01111);
        chk5("unstall_flush", flush_o, 5'b00000);
        tick();
        chk5("refull_valid", valid_o, 5'b11111);

        // redirect on a full pipe
        redirect_i = 1'b1; #1;
        chk5("redir_ok", ok_o, 5'b11111);
        chk5("redir_flush", flush_o, 5'b00110);
        tick();
        redirect_i = 1'b0; #1;
        chk5("redir_valid", valid_o, 5'b11001);
        tick(); tick(); tick(); tick();
        chk5("redir_refill", valid_o, 5'b11111);
        chk32("redir_cnt", stall_cnt_o, 32'd2);

        // redirect blocked while its stage holds, taken once released
        stall_req_i = 5'b00100; redirect_i = 1'b1; #1;
        chk5("blk_ok", ok_o, 5'b11000);
        chk5("blk_flush", flush_o, 5'b01000);
        tick();
        stall_req_i = 5'b0; #1;
        chk5("blk_valid", valid_o, 5'b10111);
        chk5("blk_take_ok", ok_o, 5'b11111);
        chk5("blk_take_flush", flush_o, 5'b10110);
        tick();
        redirect_i = 1'b0; #1;
        chk5("blk_after_valid", valid_o, 5'b01001);
        chk32("blk_cnt", stall_cnt_o, 32'd3);
        tick(); tick(); tick(); tick();
        chk5("blk_refill", valid_o, 5'b11111);

        // redirect and exception together
        redirect_i = 1'b1; exc_i = 1'b1; #1;
        chk5("rx_flush", flush_o, 5'b11110);
        chk5("rx_ok", ok_o, 5'b11111);
        tick();
        redirect_i = 1'b0; exc_i = 1'b0; #1;
        chk5("rx_valid", valid_o, 5'b00001);
        tick(); tick(); tick(); tick();
        chk5("rx_refill", valid_o, 5'b11111);

        // exception beats a stall in the same stage
        exc_i = 1'b1; stall_req_i = 5'b01000; #1;
        chk5("xs_flush", flush_o, 5'b11110);
        chk5("xs_ok", ok_o & 5'b11110, 5'b11110);
        tick();
        exc_i = 1'b0; stall_req_i = 5'b0; #1;
        chk5("xs_valid", valid_o, 5'b00001);
        tick(); tick(); tick(); tick();
        chk5("xs_refill", valid_o, 5'b11111);

        // fence in stage 1 drains stages 2..4
        fence_i = 1'b1; #1;
        chk5("fence0_ok", ok_o, 5'b11100);
        chk5("fence0_flush", flush_o, 5'b00100);
        tick();
        chk5("fence1_valid", valid_o, 5'b11011);
        chk5("fence1_ok", ok_o, 5'b11100);
        chk5("fence1_flush", flush_o, 5'b01100);
        tick();
        chk5("fence2_valid", valid_o, 5'b10011);
        chk5("fence2_ok", ok_o, 5'b11100);
        chk5("fence2_flush", flush_o, 5'b11100);
        tick();
        chk5("fence3_valid", valid_o, 5'b00011);
        chk5("fence3_ok", ok_o, 5'b11111);
        chk5("fence3_flush", flush_o, 5'b11000);
        fence_i = 1'b0;
        tick();
        chk5("fence4_valid", valid_o, 5'b00111);

        // reset while draining
        tick(); tick();
        chk5("pre_rd_valid", valid_o, 5'b11111);
        fence_i = 1'b1; #1;
        chk5("rd_enter_ok", ok_o, 5'b11100);
        tick();
        chk5("rd_drain_ok", ok_o, 5'b11100);
        rst = 1'b1; #1;
        chk5("rd_rst_ok", ok_o, 5'b11111);
        chk5("rd_rst_flush", flush_o, 5'b11110);
        tick();
        rst = 1'b0; fence_i = 1'b0; #1;
        chk5("rd_valid", valid_o, 5'b00001);
        chk32("rd_cnt", stall_cnt_o, 32'd0);
        chk5("rd_ok", ok_o, 5'b11111);
        tick();
        chk5("rd_run_valid", valid_o, 5'b00011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
